// File: rtl/sram_port_arbiter.sv
// ============================================================================
// sram_port_arbiter: zero-fills a single-port SRAM after reset, then shares its
// port between two valid/ready requesters with round-robin arbitration.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_port_arbiter #(
  parameter int unsigned ADDR_W         = 7,
  parameter int unsigned DATA_W         = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req0_valid,
  output logic              io_req0_ready,
  input  logic              io_req0_we,
  input  logic [ADDR_W-1:0] io_req0_addr,
  input  logic [DATA_W-1:0] io_req0_wdata,
  input  logic              io_req1_valid,
  output logic              io_req1_ready,
  input  logic              io_req1_we,
  input  logic [ADDR_W-1:0] io_req1_addr,
  input  logic [DATA_W-1:0] io_req1_wdata,
  output logic              io_rsp0_valid,
  output logic [DATA_W-1:0] io_rsp0_rdata,
  output logic              io_rsp1_valid,
  output logic [DATA_W-1:0] io_rsp1_rdata,
  output logic              io_init_done,
  output logic              io_sram_clk0,
  output logic              io_sram_csb0,
  output logic              io_sram_web0,
  output logic [ADDR_W-1:0] io_sram_addr0,
  output logic [DATA_W-1:0] io_sram_din0,
  input  logic [DATA_W-1:0] io_sram_dout0
);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ptr_q, ptr_d;
  logic                csb_q, csb_d;
  logic                web_q, web_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                s1_vld_q, s1_vld_d, s1_id_q;
  logic                s2_vld_q, s2_id_q;

  logic                w_gnt0, w_gnt1, w_accept, w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (state_q == ST_RUN) begin
      // Pointer breaks the tie only when both requesters are valid.
      if (io_req0_valid && (!io_req1_valid || !ptr_q)) begin
        w_gnt0 = 1'b1;
      end else if (io_req1_valid) begin
        w_gnt1 = 1'b1;
      end
    end
    w_accept    = w_gnt0 | w_gnt1;
    w_sel_we    = w_gnt1 ? io_req1_we    : io_req0_we;
    w_sel_addr  = w_gnt1 ? io_req1_addr  : io_req0_addr;
    w_sel_wdata = w_gnt1 ? io_req1_wdata : io_req0_wdata;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    csb_d    = 1'b1;
    web_d    = 1'b1;
    addr_d   = addr_q;
    din_d    = din_q;
    s1_vld_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        csb_d  = 1'b0;
        web_d  = 1'b0;
        addr_d = cnt_q;
        din_d  = '0;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == c_LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          csb_d    = 1'b0;
          web_d    = ~w_sel_we;
          addr_d   = w_sel_addr;
          din_d    = w_sel_wdata;
          ptr_d    = ~w_gnt1;
          s1_vld_d = ~w_sel_we;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      cnt_q    <= '0;
      ptr_q    <= 1'b0;
      csb_q    <= 1'b1;
      web_q    <= 1'b1;
      addr_q   <= '0;
      din_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_id_q  <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_id_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      csb_q    <= csb_d;
      web_q    <= web_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      s1_vld_q <= s1_vld_d;
      s1_id_q  <= w_gnt1;
      s2_vld_q <= s1_vld_q;
      s2_id_q  <= s1_id_q;
    end
  end

  assign io_req0_ready = w_gnt0;
  assign io_req1_ready = w_gnt1;
  assign io_init_done  = (state_q == ST_RUN);

  // Stage 2 lines up with the cycle the macro drives the addressed word.
  assign io_rsp0_valid = s2_vld_q & ~s2_id_q;
  assign io_rsp1_valid = s2_vld_q &  s2_id_q;
  assign io_rsp0_rdata = io_rsp0_valid ? io_sram_dout0 : '0;
  assign io_rsp1_rdata = io_rsp1_valid ? io_sram_dout0 : '0;

  assign io_sram_clk0  = clock;
  assign io_sram_csb0  = csb_q;
  assign io_sram_web0  = web_q;
  assign io_sram_addr0 = addr_q;
  assign io_sram_din0  = din_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// tb_sram_port_arbiter: directed bench with a behavioural SRAM model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_valid, r0_we, r1_valid, r1_we;
  logic [6:0]  r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;
  logic        r0_ready, r1_ready, p0_valid, p1_valid, init_done;
  logic [31:0] p0_rdata, p1_rdata;
  logic        s_clk, s_csb, s_web;
  logic [6:0]  s_addr;
  logic [31:0] s_din, s_dout;

  logic        b_valid, b_we;
  logic [6:0]  b_addr;
  logic [31:0] b_wdata;
  logic        b_ready0, b_ready1, b_p0_valid, b_p1_valid, b_init_done;
  logic [31:0] b_p0_rdata, b_p1_rdata;
  logic        b_clk, b_csb, b_web;
  logic [6:0]  b_saddr;
  logic [31:0] b_din;
  logic [31:0] b_dout = 32'h0;
  logic        b_idle = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(7), .DATA_W(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clock(clk), .reset(reset),
    .io_req0_valid(r0_valid), .io_req0_ready(r0_ready), .io_req0_we(r0_we),
    .io_req0_addr(r0_addr), .io_req0_wdata(r0_wdata),
    .io_req1_valid(r1_valid), .io_req1_ready(r1_ready), .io_req1_we(r1_we),
    .io_req1_addr(r1_addr), .io_req1_wdata(r1_wdata),
    .io_rsp0_valid(p0_valid), .io_rsp0_rdata(p0_rdata),
    .io_rsp1_valid(p1_valid), .io_rsp1_rdata(p1_rdata),
    .io_init_done(init_done), .io_sram_clk0(s_clk), .io_sram_csb0(s_csb),
    .io_sram_web0(s_web), .io_sram_addr0(s_addr), .io_sram_din0(s_din),
    .io_sram_dout0(s_dout)
  );

  sram_port_arbiter #(.ADDR_W(7), .DATA_W(32), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clock(clk), .reset(reset),
    .io_req0_valid(b_valid), .io_req0_ready(b_ready0), .io_req0_we(b_we),
    .io_req0_addr(b_addr), .io_req0_wdata(b_wdata),
    .io_req1_valid(b_idle), .io_req1_ready(b_ready1), .io_req1_we(b_idle),
    .io_req1_addr(b_addr), .io_req1_wdata(b_wdata),
    .io_rsp0_valid(b_p0_valid), .io_rsp0_rdata(b_p0_rdata),
    .io_rsp1_valid(b_p1_valid), .io_rsp1_rdata(b_p1_rdata),
    .io_init_done(b_init_done), .io_sram_clk0(b_clk), .io_sram_csb0(b_csb),
    .io_sram_web0(b_web), .io_sram_addr0(b_saddr), .io_sram_din0(b_din),
    .io_sram_dout0(b_dout)
  );

  // Macro model: seeded with non-zero junk so a missing clear is visible.
  logic [31:0] mem [128];
  logic        seeded = 1'b0;
  always @(posedge s_clk) begin
    if (!seeded) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'hBAD0_0000 | i;
      seeded <= 1'b1;
    end else if (!s_csb) begin
      if (!s_web) mem[s_addr] <= s_din;
      else        s_dout      <= mem[s_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    r0_valid = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_valid = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    s_dout = 32'h0;
    tick();
    tick();
    chk("rst_csb", s_csb, 1);
    chk("rst_web", s_web, 1);
    chk("rst_addr", s_addr, 0);
    chk("rst_din", s_din, 0);
    chk("rst_rsp0", p0_valid, 0);
    chk("rst_rsp1", p1_valid, 0);
    chk("rst_rdy0", r0_ready, 0);
    chk("rst_done", init_done, 0);
    reset = 1'b0;

    // Cycle 0: the no-clear instance is already running.
    b_valid = 1; b_we = 0; b_addr = 7'd3;
    #1;
    chk("nc_done", b_init_done, 1);
    chk("nc_rdy0", b_ready0, 1);

    for (int c = 0; c < 128; c++) begin
      chk("init_done_lo", init_done, 0);
      chk("init_rdy0", r0_ready, 0);
      if (c == 0) begin
        chk("init_csb0", s_csb, 1);
      end else begin
        chk("init_csb", s_csb, 0);
        chk("init_web", s_web, 0);
        chk("init_addr", s_addr, c - 1);
        chk("init_din", s_din, 0);
      end
      if (c == 1) begin
        chk("nc_csb", b_csb, 0);
        chk("nc_web", b_web, 1);
        chk("nc_addr", b_saddr, 3);
        b_valid = 0;
      end
      tick();
    end

    // Cycle 128
    chk("init_done_hi", init_done, 1);
    chk("last_clear_addr", s_addr, 127);
    chk("last_clear_csb", s_csb, 0);
    r0_valid = 1; r0_we = 1; r0_addr = 7'd5; r0_wdata = 32'hDEADBEEF;
    #1;
    chk("wr5_rdy0", r0_ready, 1);
    chk("wr5_rdy1", r1_ready, 0);
    tick();
    chk("wr5_csb", s_csb, 0);
    chk("wr5_web", s_web, 0);
    chk("wr5_addr", s_addr, 5);
    chk("wr5_din", s_din, 32'hDEADBEEF);
    r0_we = 0;
    #1;
    chk("rd5_rdy0", r0_ready, 1);
    tick();
    chk("rd5_web", s_web, 1);
    chk("rd5_rsp0_early", p0_valid, 0);
    r0_valid = 0;
    tick();
    chk("rd5_rsp0", p0_valid, 1);
    chk("rd5_data", p0_rdata, 32'hDEADBEEF);
    chk("rd5_rsp1", p1_valid, 0);
    chk("idle_csb", s_csb, 1);

    r0_valid = 1; r0_we = 1; r0_addr = 7'd1; r0_wdata = 32'h1111_1111;
    #1;
    chk("wr1_rdy0", r0_ready, 1);
    tick();
    chk("wr1_addr", s_addr, 1);
    r0_valid = 0;
    r1_valid = 1; r1_we = 1; r1_addr = 7'd2; r1_wdata = 32'h2222_2222;
    #1;
    chk("wr2_rdy1", r1_ready, 1);
    tick();
    chk("wr2_addr", s_addr, 2);
    chk("wr2_din", s_din, 32'h2222_2222);

    r0_valid = 1; r0_we = 0; r0_addr = 7'd1;
    r1_valid = 1; r1_we = 0; r1_addr = 7'd2;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_rdy0", r0_ready, (i % 2 == 0));
      chk("rr_rdy1", r1_ready, (i % 2 == 1));
      tick();
      chk("rr_csb", s_csb, 0);
      chk("rr_web", s_web, 1);
      chk("rr_addr", s_addr, (i % 2 == 1) ? 2 : 1);
      if (i >= 1) begin
        chk("rr_rsp0", p0_valid, ((i - 1) % 2 == 0));
        chk("rr_rsp1", p1_valid, ((i - 1) % 2 == 1));
        if ((i - 1) % 2 == 0) chk("rr_data0", p0_rdata, 32'h1111_1111);
        else                  chk("rr_data1", p1_rdata, 32'h2222_2222);
      end else begin
        chk("rr_rsp_none", {p0_valid, p1_valid}, 0);
      end
    end
    r0_valid = 0; r1_valid = 0;
    tick();
    chk("rr_tail_rsp1", p1_valid, 1);
    chk("rr_tail_data", p1_rdata, 32'h2222_2222);
    chk("rr_tail_csb", s_csb, 1);

    r1_valid = 1; r1_we = 0; r1_addr = 7'd100;
    #1;
    chk("rd100_rdy1", r1_ready, 1);
    tick();
    r1_valid = 0;
    tick();
    chk("rd100_rsp1", p1_valid, 1);
    chk("rd100_data", p1_rdata, 32'h0);
    chk("rd100_rsp0", p0_valid, 0);
    chk("rd100_rdata0", p0_rdata, 32'h0);

    r0_valid = 1; r0_we = 0; r0_addr = 7'd1;
    #1;
    chk("mr_rdy0", r0_ready, 1);
    tick();
    r0_valid = 0;
    r1_valid = 1; r1_we = 0; r1_addr = 7'd2;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    r1_valid = 0;
    chk("mr_done", init_done, 0);
    for (int c = 0; c < 4; c++) begin
      chk("mr_rsp0", p0_valid, 0);
      chk("mr_rsp1", p1_valid, 0);
      if (c == 0) begin
        chk("mr_csb0", s_csb, 1);
      end else begin
        chk("mr_csb", s_csb, 0);
        chk("mr_addr", s_addr, c - 1);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
